text_glyph_fetch: RTL and testbench
===================================

Name: text_glyph_fetch

Overview:
- Text-mode video controller that sequences the 4kx8 font ROM and the text (character-code) RAM for every visible pixel.
- Tracks pixel, cell and glyph-row position from incoming video timing, and issues the text RAM address and then the font ROM address.
- Selects the glyph bit, overlays a blinking underline cursor, and emits RGB plus timing delayed by the fetch latency.
- Sits between the video timing generator and the HDMI encoder.

Parameters:
- COLS, 80, text columns per row
- ROWS, 30, text rows per frame
- ADDR_W, 12, text RAM address width
- BLINK_FRAMES, 30, frames per cursor blink phase
- FG, 24'hFFFFFF, foreground RGB
- BG, 24'h000000, background RGB

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- de_in  in  1  display enable from timing generator
- hsync_in  in  1  hsync (polarity passed through)
- vsync_in  in  1  vsync, active-high
- text_addr  out  ADDR_W  text RAM read address; combinational from internal registers
- text_data  in  8  character code; 1-cycle synchronous read
- font_addr  out  12  {text_data, glyph_row}; combinational
- font_data  in  8  glyph byte; 1-cycle synchronous read; bit 7 = leftmost pixel
- cursor_col  in  7  cursor column
- cursor_row  in  5  cursor row
- cursor_en  in  1  cursor enable
- de_out  out  1  de_in delayed 3 cycles
- hsync_out  out  1  hsync_in delayed 3 cycles
- vsync_out  out  1  vsync_in delayed 3 cycles
- rgb  out  24  pixel colour, aligned with de_out

Behaviour:
- Reset: all counters 0, synced=0, blink=0; de_out/hsync_out/vsync_out=0; rgb=BG; all delay-pipe stages cleared.
- synced flag: set on the first vsync_in rising edge after reset. While synced=0, rgb=BG regardless of glyph data. Timing outputs are still delayed normally.
- Frame start (vsync_in rising edge): sub_x=0, cell_col=0, glyph_row=0, text_row=0, line_base=0.
  - blink_cnt increments. At BLINK_FRAMES-1 it wraps to 0 and the blink bit toggles.
- Pixel counter, per cycle with de_in=1:
  - sub_x increments mod 8.
  - When sub_x==7, cell_col increments, saturating at COLS.
- End of line (de_in falling edge): sub_x=0, cell_col=0, glyph_row increments mod 16.
  - On glyph_row wrap 15->0: text_row increments (saturating at ROWS) and line_base += COLS. No multiplier.
- text_addr = line_base + cell_col, truncated to ADDR_W. It is driven every cycle; its value outside de_in is don't-care.
- Pipeline:
  - Stage 0 (cycle t): text_addr issued.
  - Stage 1 (t+1): font_addr = {text_data, glyph_row_d1}.
  - Stage 2 (t+2): bit = font_data[7 - sub_x_d2].
  - Registered into rgb at t+3.
- The side-band carried alongside the pipeline (sub_x, glyph_row, cell_col, text_row, de) is delayed to match each stage.
- Cursor: at stage 2, if cursor_en && blink && cell_col_d2==cursor_col && text_row_d2==cursor_row && glyph_row_d2 in {14,15}, the bit is inverted.
- rgb selection:
  - rgb = bit ? FG : BG when de_d2 && synced && cell_col_d2<COLS && text_row_d2<ROWS.
  - Otherwise rgb = BG.
- Out-of-range cells (col>=COLS or row>=ROWS) always show BG, and text_addr does not advance past the saturated value.
- Simultaneous vsync rising edge and de falling edge: frame start wins; counters are 0 afterwards.
- Reset mid-frame: the entire pipeline is flushed and the block returns to synced=0. Output stays BG until the next vsync rising edge.

Test Plan:
- Reset then 640x480 timing; no vsync yet -> rgb=BG throughout; de_out equals de_in delayed exactly 3 cycles.
- After vsync, text RAM model returns 8'h41 at address 0 and font model returns 8'b1000_0001 for rows of 0x41 -> pixels 0 and 7 of line 0 are FG, pixels 1-6 are BG; font_addr=12'h410 on line 0 and 12'h41F on line 15.
- Line 16, first de cycle -> text_addr=80 (12'h050); line 479, last cell -> text_addr=2399.
- Cursor at col 3, row 0, cursor_en=1, BLINK_FRAMES=2, blank font -> pixels 24-31 on lines 14-15 are FG only in frames where blink=1; toggles every 2 frames.
- Timing with 700 active pixels/line -> pixels 640-699 are BG; text_addr holds line_base+80.
- Assert rst mid-line for 1 cycle -> next cycle de_out=0 and rgb=BG; BG persists until the next vsync rising edge; correct glyphs resume in the following frame.

Source files
------------

// File: rtl/text_glyph_fetch.sv
// Text-mode glyph fetch: walks text RAM and font ROM per pixel,
// overlays a blinking underline cursor and emits RGB with aligned timing.
module text_glyph_fetch #(
  parameter int          COLS         = 80,
  parameter int          ROWS         = 30,
  parameter int          ADDR_W       = 12,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [23:0] FG           = 24'hFFFFFF,
  parameter logic [23:0] BG           = 24'h000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              de_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic [ADDR_W-1:0] text_addr,
  input  logic [7:0]        text_data,
  output logic [11:0]       font_addr,
  input  logic [7:0]        font_data,
  input  logic [6:0]        cursor_col,
  input  logic [4:0]        cursor_row,
  input  logic              cursor_en,
  output logic              de_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic [23:0]       rgb
);

  localparam int BW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0]     BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [6:0]        COLS_C     = 7'(COLS);
  localparam logic [4:0]        ROWS_C     = 5'(ROWS);
  localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);

  logic              vsync_q;
  logic              de_q;
  logic              vs_rise;
  logic              de_fall;
  logic              synced;
  logic              blink;
  logic [BW-1:0]     blink_cnt;

  logic [2:0]        sub_x;
  logic [6:0]        cell_col;
  logic [3:0]        glyph_row;
  logic [4:0]        text_row;
  logic [ADDR_W-1:0] line_base;

  logic [2:0]        s1_sub_x;
  logic [3:0]        s1_glyph_row;
  logic [6:0]        s1_col;
  logic [4:0]        s1_row;
  logic              s1_de;
  logic              s1_hs;
  logic              s1_vs;

  logic [2:0]        s2_sub_x;
  logic [3:0]        s2_glyph_row;
  logic [6:0]        s2_col;
  logic [4:0]        s2_row;
  logic              s2_de;
  logic              s2_hs;
  logic              s2_vs;

  logic              glyph_bit;
  logic              cursor_hit;
  logic              pix;
  logic              visible;
  logic [23:0]       rgb_next;

  assign vs_rise = vsync_in & ~vsync_q;
  assign de_fall = ~de_in & de_q;

  assign text_addr = line_base + ADDR_W'(cell_col);
  assign font_addr = {text_data, s1_glyph_row};

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q   <= 1'b0;
      de_q      <= 1'b0;
      synced    <= 1'b0;
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else begin
      vsync_q <= vsync_in;
      de_q    <= de_in;
      if (vs_rise) begin
        synced <= 1'b1;
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink     <= ~blink;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // Frame start outranks end-of-line when both land on one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_x     <= '0;
      cell_col  <= '0;
      glyph_row <= '0;
      text_row  <= '0;
      line_base <= '0;
    end else if (vs_rise) begin
      sub_x     <= '0;
      cell_col  <= '0;
      glyph_row <= '0;
      text_row  <= '0;
      line_base <= '0;
    end else if (de_fall) begin
      sub_x     <= '0;
      cell_col  <= '0;
      glyph_row <= glyph_row + 4'd1;
      if (glyph_row == 4'd15 && text_row < ROWS_C) begin
        text_row  <= text_row + 5'd1;
        line_base <= line_base + COLS_A;
      end
    end else if (de_in) begin
      sub_x <= sub_x + 3'd1;
      if (sub_x == 3'd7 && cell_col < COLS_C) begin
        cell_col <= cell_col + 7'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sub_x     <= '0;
      s1_glyph_row <= '0;
      s1_col       <= '0;
      s1_row       <= '0;
      s1_de        <= 1'b0;
      s1_hs        <= 1'b0;
      s1_vs        <= 1'b0;
      s2_sub_x     <= '0;
      s2_glyph_row <= '0;
      s2_col       <= '0;
      s2_row       <= '0;
      s2_de        <= 1'b0;
      s2_hs        <= 1'b0;
      s2_vs        <= 1'b0;
    end else begin
      s1_sub_x     <= sub_x;
      s1_glyph_row <= glyph_row;
      s1_col       <= cell_col;
      s1_row       <= text_row;
      s1_de        <= de_in;
      s1_hs        <= hsync_in;
      s1_vs        <= vsync_in;
      s2_sub_x     <= s1_sub_x;
      s2_glyph_row <= s1_glyph_row;
      s2_col       <= s1_col;
      s2_row       <= s1_row;
      s2_de        <= s1_de;
      s2_hs        <= s1_hs;
      s2_vs        <= s1_vs;
    end
  end

  // Bit 7 of the glyph byte is the leftmost pixel.
  always_comb begin
    glyph_bit  = font_data[3'd7 - s2_sub_x];
    cursor_hit = cursor_en && blink
              && s2_col == cursor_col
              && s2_row == cursor_row
              && s2_glyph_row[3:1] == 3'b111;
    pix        = glyph_bit ^ cursor_hit;
    visible    = s2_de && synced
              && s2_col < COLS_C
              && s2_row < ROWS_C;
    rgb_next   = BG;
    if (visible && pix) begin
      rgb_next = FG;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      rgb       <= BG;
    end else begin
      de_out    <= s2_de;
      hsync_out <= s2_hs;
      vsync_out <= s2_vs;
      rgb       <= rgb_next;
    end
  end

endmodule

// File: tb/tb_text_glyph_fetch.sv
// Bench for text_glyph_fetch: small text grid, memory models,
// scoreboard of per-pixel expectations plus address and cursor tables.
module tb_text_glyph_fetch;

  localparam int          COLS = 4;
  localparam int          ROWS = 3;
  localparam int          AW   = 12;
  localparam int          BF   = 2;
  localparam logic [23:0] FG   = 24'hFFFFFF;
  localparam logic [23:0] BG   = 24'h000000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          de_in = 1'b0;
  logic          hsync_in = 1'b0;
  logic          vsync_in = 1'b0;
  logic [AW-1:0] text_addr;
  logic [7:0]    text_data;
  logic [11:0]   font_addr;
  logic [7:0]    font_data;
  logic [6:0]    cursor_col = 7'd3;
  logic [4:0]    cursor_row = 5'd0;
  logic          cursor_en = 1'b0;
  logic          de_out;
  logic          hsync_out;
  logic          vsync_out;
  logic [23:0]   rgb;

  text_glyph_fetch #(
    .COLS(COLS), .ROWS(ROWS), .ADDR_W(AW),
    .BLINK_FRAMES(BF), .FG(FG), .BG(BG)
  ) dut (
    .clk(clk), .rst(rst),
    .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .text_addr(text_addr), .text_data(text_data),
    .font_addr(font_addr), .font_data(font_data),
    .cursor_col(cursor_col), .cursor_row(cursor_row),
    .cursor_en(cursor_en),
    .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .rgb(rgb)
  );

  always #5 clk = ~clk;

  logic [7:0] text_mem [4096];
  logic [7:0] font_mem [4096];

  always @(posedge clk) begin
    text_data <= text_mem[text_addr];
    font_data <= font_mem[font_addr];
  end

  typedef struct {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
    bit          cur;
    int          x;
    int          y;
  } exp_t;

  typedef struct {
    int w;
    int h;
    bit vs;
    bit cur_en;
    int cur_fg;
    bit early;
    int rst_y;
  } frm_t;

  typedef struct {
    int          f;
    int          y;
    int          x;
    logic [11:0] ta;
    logic [11:0] fa;
  } av_t;

  exp_t sq[$];
  frm_t frames[9];
  av_t  avec[10];
  frm_t cfg;

  int tests = 0;
  int fails = 0;
  int cur_f = 0;
  int cur_fg_cnt = 0;
  bit pend = 0;
  logic [11:0] pend_fa = '0;
  bit chk_rst = 0;

  bit synced_m = 0;
  bit bl_m = 0;
  bit vs_prev_m = 0;
  int bcnt_m = 0;

  function automatic exp_t rst_entry();
    exp_t e;
    e.de = 1'b0; e.hs = 1'b0; e.vs = 1'b0;
    e.rgb = BG; e.cur = 0; e.x = -1; e.y = -1;
    return e;
  endfunction

  function automatic logic [23:0] px_exp(int x, int y);
    int col;
    int row;
    logic [7:0] code;
    logic [7:0] g;
    logic b;
    col = x / 8;
    row = y / 16;
    if (!synced_m || col >= COLS || row >= ROWS) return BG;
    code = text_mem[row * COLS + col];
    g = font_mem[{code, 4'(y % 16)}];
    b = g[7 - (x % 8)];
    if (cfg.cur_en && bl_m && col == 3 && row == 0 && (y % 16) >= 14)
      b = ~b;
    return b ? FG : BG;
  endfunction

  task automatic step(input logic r, input logic d, input logic h,
                      input logic v, input int x, input int y);
    exp_t e;
    exp_t n;
    @(negedge clk);
    e = sq.pop_front();
    tests++;
    if (de_out !== e.de || hsync_out !== e.hs ||
        vsync_out !== e.vs || rgb !== e.rgb) begin
      fails++;
      $display("FAIL pix f=%0d x=%0d y=%0d got de=%b hs=%b vs=%b rgb=%h want de=%b hs=%b vs=%b rgb=%h",
               cur_f, e.x, e.y, de_out, hsync_out, vsync_out, rgb,
               e.de, e.hs, e.vs, e.rgb);
    end
    if (e.cur && rgb == FG) cur_fg_cnt++;
    if (pend) begin
      tests++;
      if (font_addr !== pend_fa) begin
        fails++;
        $display("FAIL font_addr f=%0d got %h want %h",
                 cur_f, font_addr, pend_fa);
      end
      pend = 0;
    end
    if (chk_rst) begin
      tests++;
      if (de_out !== 1'b0 || rgb !== BG) begin
        fails++;
        $display("FAIL after_rst got de=%b rgb=%h want de=0 rgb=%h",
                 de_out, rgb, BG);
      end
      chk_rst = 0;
    end
    rst = r; de_in = d; hsync_in = h; vsync_in = v;
    if (r) begin
      synced_m = 0; bl_m = 0; bcnt_m = 0; vs_prev_m = 0;
      foreach (sq[i]) sq[i] = rst_entry();
      n = rst_entry();
      chk_rst = 1;
    end else begin
      if (v && !vs_prev_m) begin
        synced_m = 1;
        if (bcnt_m == BF - 1) begin
          bcnt_m = 0;
          bl_m = ~bl_m;
        end else begin
          bcnt_m++;
        end
      end
      vs_prev_m = v;
      n.de = d; n.hs = h; n.vs = v;
      n.rgb = d ? px_exp(x, y) : BG;
      n.cur = d && cfg.cur_en && x >= 24 && x < 32 && y >= 14 && y < 16;
      n.x = x; n.y = y;
    end
    sq.push_back(n);
    if (!r && d) begin
      for (int i = 0; i < 10; i++) begin
        if (avec[i].f == cur_f && avec[i].y == y && avec[i].x == x) begin
          tests++;
          if (text_addr !== avec[i].ta) begin
            fails++;
            $display("FAIL text_addr f=%0d y=%0d x=%0d got %0d want %0d",
                     cur_f, y, x, text_addr, avec[i].ta);
          end
          pend = 1;
          pend_fa = avec[i].fa;
        end
      end
    end
  endtask

  task automatic do_line(input bit act, input int y,
                         input bit vs, input bit early);
    for (int x = 0; x < cfg.w + 8; x++) begin
      logic d, h, v, r;
      d = act && x < cfg.w;
      h = x >= cfg.w + 2 && x < cfg.w + 6;
      v = vs || (early && x >= cfg.w);
      r = act && cfg.rst_y == y && x == 10;
      step(r, d, h, v, x, y);
    end
  endtask

  task automatic run_frame(input int f);
    cfg = frames[f];
    cur_f = f;
    cur_fg_cnt = 0;
    cursor_en = cfg.cur_en;
    for (int l = 0; l < 2; l++) do_line(0, -1, cfg.vs, 0);
    for (int l = 0; l < 2; l++) do_line(0, -1, 0, 0);
    for (int y = 0; y < cfg.h; y++)
      do_line(1, y, 0, cfg.early && y == cfg.h - 1);
    if (!cfg.early) do_line(0, -1, 0, 0);
    if (cfg.cur_en) begin
      tests++;
      if (cur_fg_cnt != cfg.cur_fg) begin
        fails++;
        $display("FAIL cursor f=%0d fg_pixels=%0d want %0d",
                 f, cur_fg_cnt, cfg.cur_fg);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      text_mem[i] = 8'($urandom);
      font_mem[i] = 8'($urandom);
    end
    for (int i = 0; i < 64; i++) text_mem[i] = 8'h41 + 8'(i);
    for (int r = 0; r < 16; r++) begin
      font_mem[{8'h41, 4'(r)}] = 8'b1000_0001;
      font_mem[{8'h44, 4'(r)}] = 8'h00;
    end

    //           w   h  vs cur fg early rst_y
    frames[0] = '{32, 48, 0, 0, 0,  0, -1};
    frames[1] = '{32, 48, 1, 0, 0,  0, -1};
    frames[2] = '{32, 48, 1, 1, 16, 0, -1};
    frames[3] = '{32, 48, 1, 1, 16, 0, -1};
    frames[4] = '{32, 48, 1, 1, 0,  0, -1};
    frames[5] = '{32, 48, 1, 1, 0,  1, -1};
    frames[6] = '{40, 52, 1, 0, 0,  0, -1};
    frames[7] = '{32, 48, 1, 0, 0,  0, 5};
    frames[8] = '{32, 48, 1, 0, 0,  0, -1};

    avec[0] = '{1, 0,  0,  12'd0,  12'h410};
    avec[1] = '{1, 0,  8,  12'd1,  12'h420};
    avec[2] = '{1, 15, 0,  12'd0,  12'h41F};
    avec[3] = '{1, 16, 0,  12'd4,  12'h450};
    avec[4] = '{1, 47, 31, 12'd11, 12'h4CF};
    avec[5] = '{6, 0,  39, 12'd4,  12'h450};
    avec[6] = '{6, 16, 36, 12'd8,  12'h490};
    avec[7] = '{6, 50, 0,  12'd12, 12'h4D2};
    avec[8] = '{8, 0,  0,  12'd0,  12'h410};
    avec[9] = '{8, 16, 8,  12'd5,  12'h460};

    cfg = frames[0];
    repeat (3) sq.push_back(rst_entry());
    repeat (4) step(1, 0, 0, 0, -1, -1);
    for (int f = 0; f < 9; f++) run_frame(f);
    repeat (4) step(0, 0, 0, 0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
